uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with input FIFO and valid/ready handshake.

---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; queued bytes leave back-to-back with no idle gap.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_BITS-1:0]        in_data,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;
    localparam int unsigned IDX_W        = 3;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_next;
    logic [BAUD_W-1:0]    baud_cnt, baud_next;
    logic [IDX_W-1:0]     bit_idx, idx_next;
    logic [DATA_BITS-1:0] shift_data, shift_next;
    logic                 tx_next;
    logic                 pop;
    logic                 push;
    logic                 bit_end;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit, parity_next;
`endif

    assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign busy     = (state != IDLE) | (fifo_count != '0);
    assign bit_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    // Next-state, next-output and FIFO pop decision
    always_comb begin
        state_next = state;
        baud_next  = (state == IDLE || bit_end) ? '0 : baud_cnt + BAUD_W'(1);
        idx_next   = bit_idx;
        shift_next = shift_data;
        tx_next    = tx;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        unique case (state)
            IDLE: pop = (fifo_count != '0);
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                    tx_next    = shift_data[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_bit;
`else
                        state_next = STOP;
                        idx_next   = '0;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        idx_next   = bit_idx + IDX_W'(1);
                        shift_next = shift_data >> 1;
                        tx_next    = shift_data[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    idx_next   = '0;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        if (fifo_count != '0) pop = 1'b1;
                        else                  state_next = IDLE;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A pop always launches a fresh start bit, from IDLE or straight out of STOP
        if (pop) begin
            state_next = START;
            baud_next  = '0;
            tx_next    = 1'b0;
            shift_next = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_next = (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif
        end
    end

    // FSM, line and FIFO bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_data <= '0;
            tx         <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= idx_next;
            shift_data <= shift_next;
            tx         <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 even-parity instance and a 7-data/2-stop odd-parity instance.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int          CPB    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid_a = 1'b0, in_ready_a, tx_a, busy_a;
    logic [7:0] in_data_a = '0;
    logic [2:0] count_a;
    logic       in_valid_b = 1'b0, in_ready_b, tx_b, busy_b;
    logic [6:0] in_data_b = '0;
    logic [2:0] count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1),
                   .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .tx(tx_a), .busy(busy_a), .fifo_count(count_a));

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2),
                   .FIFO_DEPTH(4), .PARITY_ODD(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .tx(tx_b), .busy(busy_b), .fifo_count(count_b));

    typedef struct {
        string      name;
        int         inst;
        logic [7:0] data;
        logic [11:0] bits_np;   // line bits, slot 0 first, without parity
        logic [11:0] bits_p;    // line bits with parity
        int         nbits_np;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_tx(input int inst);
        return (inst == 0) ? tx_a : tx_b;
    endfunction
    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic get_ready(input int inst);
        return (inst == 0) ? in_ready_a : in_ready_b;
    endfunction
    function automatic logic [2:0] get_count(input int inst);
        return (inst == 0) ? count_a : count_b;
    endfunction

    function automatic logic [11:0] frame_bits(input logic [7:0] d, input int nd,
                                               input int ns, input bit odd);
        logic [11:0] f = '0;
        int          k = 1;
        logic        p = odd;
        for (int j = 0; j < nd; j++) begin
            f[k] = d[j];
            p    = p ^ d[j];
            k++;
        end
        if (PAR != 0) begin
            f[k] = p;
            k++;
        end
        for (int j = 0; j < ns; j++) begin
            f[k] = 1'b1;
            k++;
        end
        return f;
    endfunction

    task automatic push(input int inst, input logic [7:0] d);
        if (inst == 0) begin in_valid_a = 1'b1; in_data_a = d; end
        else           begin in_valid_b = 1'b1; in_data_b = d[6:0]; end
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_fall(input int inst, input int limit, output int lat);
        lat = 0;
        while (get_tx(inst) !== 1'b0 && lat < limit) begin
            tick();
            lat++;
        end
        if (get_tx(inst) !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL start bit timeout: tx still %b after %0d cycles", get_tx(inst), lat);
        end
    endtask

    // Called on the first start-bit cycle; returns on the first cycle after the frame
    task automatic check_frame(input int inst, input logic [11:0] bits, input int nbits,
                               input string name);
        for (int i = 0; i < nbits * CPB; i++) begin
            int ph = i % CPB;
            if (ph == 0 || ph == CPB - 1)
                check($sformatf("%s slot%0d c%0d", name, i / CPB, ph), get_tx(inst), bits[i / CPB]);
            if (i == nbits * CPB - 1)
                check($sformatf("%s busy last", name), get_busy(inst), 1);
            tick();
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int          lat;
        int          nb = v.nbits_np + PAR;
        logic [11:0] b  = (PAR != 0) ? v.bits_p : v.bits_np;
        check({v.name, " ready"}, get_ready(v.inst), 1);
        push(v.inst, v.data);
        wait_fall(v.inst, 5, lat);
        check({v.name, " latency"}, lat, 1);
        check_frame(v.inst, b, nb, v.name);
        check({v.name, " busy end"}, get_busy(v.inst), 0);
        check({v.name, " tx idle"}, get_tx(v.inst), 1);
        check({v.name, " count end"}, get_count(v.inst), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v55;
        vecs[0] = '{"a5_8b",  0, 8'hA5, 12'h34A, 12'h54A, 10};
        vecs[1] = '{"07_8b",  0, 8'h07, 12'h20E, 12'h60E, 10};
        vecs[2] = '{"03_8b",  0, 8'h03, 12'h206, 12'h406, 10};
        vecs[3] = '{"7f_7b2", 1, 8'h7F, 12'h3FE, 12'h6FE, 10};
        vecs[4] = '{"03_7b2", 1, 8'h03, 12'h306, 12'h706, 10};
        vecs[5] = '{"07_7b2", 1, 8'h07, 12'h30E, 12'h60E, 10};
        v55     = '{"55_after_reset", 0, 8'h55, 12'h2AA, 12'h4AA, 10};

        // Reset values, then idle hold
        repeat (3) tick();
        check("rst tx_a", tx_a, 1);
        check("rst busy_a", busy_a, 0);
        check("rst ready_a", in_ready_a, 1);
        check("rst count_a", count_a, 0);
        check("rst tx_b", tx_b, 1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4) begin
                check("idle tx_a", tx_a, 1);
                check("idle busy_a", busy_a, 0);
                check("idle count_a", count_a, 0);
                check("idle ready_b", in_ready_b, 1);
            end
        end

        // Single frames from the table
        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Six pushes into a depth-4 FIFO: stall, then six back-to-back frames
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    int guard = 0;
                    in_data_a  = 8'(k);
                    in_valid_a = 1'b1;
                    while (!in_ready_a && guard < 300) begin
                        if (guard == 0) begin
                            check("burst stall count", count_a, 4);
                            check("burst stall byte", k, 6);
                        end
                        tick();
                        guard++;
                    end
                    if (!in_ready_a) begin
                        checks++;
                        errors++;
                        $display("FAIL burst push timeout: byte %0d ready %b", k, in_ready_a);
                    end
                    tick();
                end
                in_valid_a = 1'b0;
            end
            begin
                int lat;
                wait_fall(0, 5, lat);
                check("burst latency", lat, 2);
                for (int k = 1; k <= 6; k++)
                    check_frame(0, frame_bits(8'(k), 8, 1, 1'b0), 10 + PAR,
                                $sformatf("burst%0d", k));
            end
        join
        check("burst busy end", busy_a, 0);
        check("burst tx end", tx_a, 1);
        check("burst count end", count_a, 0);

        // Reset during data bit 3 with two bytes queued
        begin
            int lat;
            push(0, 8'h11);
            wait_fall(0, 5, lat);
            push(0, 8'h22);
            push(0, 8'h33);
            for (int j = 0; j < 43; j++) tick();
            check("midframe bit3", tx_a, 0);
            check("midframe count", count_a, 2);
            #2 reset = 1'b1;
            #1;
            check("async rst tx", tx_a, 1);
            check("async rst count", count_a, 0);
            check("async rst busy", busy_a, 0);
            check("async rst ready", in_ready_a, 1);
            tick();
            reset = 1'b0;
            for (int j = 0; j < 15; j++) begin
                tick();
                if (tx_a !== 1'b1 || busy_a !== 1'b0)
                    check("post rst quiet", {tx_a, busy_a}, 2'b10);
            end
            check("post rst idle tx", tx_a, 1);
            check("post rst idle busy", busy_a, 0);
            apply_vec(v55);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
